// File: rtl/tdc_fifo_scheduler.sv
// Round-robin arbiter with per-grant burst quota that feeds the event FIFO write port
// from several TDC channels, and flushes and counts events from disabled channels.
module tdc_fifo_scheduler #(
  parameter int NUMBER_CHANNEL   = 2,
  parameter int FIFO_DATA_LENGTH = 68,
  parameter int BURST_MAX        = 4,
  parameter int DROP_CNT_WIDTH   = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUMBER_CHANNEL-1:0]                  req_valid,
  input  logic [NUMBER_CHANNEL*FIFO_DATA_LENGTH-1:0] req_data,
  input  logic [NUMBER_CHANNEL-1:0]                  enable_mask,
  input  logic                                       fifo_full,
  input  logic                                       clear_drops,
  output logic [NUMBER_CHANNEL-1:0]                  req_ack,
  output logic [FIFO_DATA_LENGTH-1:0]                o_data,
  output logic                                       write,
  output logic [NUMBER_CHANNEL-1:0]                  sel_onehot,
  output logic [NUMBER_CHANNEL*DROP_CNT_WIDTH-1:0]   drop_count
);

  localparam int N  = NUMBER_CHANNEL;
  localparam int W  = FIFO_DATA_LENGTH;
  localparam int DW = DROP_CNT_WIDTH;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic {DECIDE, XFER} state_t;

  state_t         state_reg, state_next;
  logic [PW-1:0]  ptr_reg, ptr_next;
  logic [PW-1:0]  last_reg, last_next;
  logic [BW-1:0]  burst_reg, burst_next;
  logic [W-1:0]   o_data_reg, o_data_next;
  logic           write_reg, write_next;
  logic [N-1:0]   ack_reg, ack_next;
  logic [N-1:0]   sel_reg, sel_next;

  logic [N-1:0]   eligible, flush, grant_onehot;
  logic [PW-1:0]  grant, grant_hi, grant_lo;
  logic           found_hi, found_lo;
  logic [BW-1:0]  new_burst;
  logic [W-1:0]   grant_data;

  always_comb begin
    // A channel whose ack is high this cycle still shows its consumed event; ignore it.
    eligible = req_valid & enable_mask & ~ack_reg;
    flush    = req_valid & ~enable_mask & ~ack_reg;

    found_hi = 1'b0;
    found_lo = 1'b0;
    grant_hi = '0;
    grant_lo = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_lo = PW'(i);
        found_lo = 1'b1;
        if (PW'(i) >= ptr_reg) begin
          grant_hi = PW'(i);
          found_hi = 1'b1;
        end
      end
    end
    grant = found_hi ? grant_hi : grant_lo;

    grant_onehot = '0;
    grant_data   = '0;
    for (int i = 0; i < N; i++) begin
      if (PW'(i) == grant) begin
        grant_onehot[i] = 1'b1;
        grant_data      = req_data[i*W +: W];
      end
    end

    new_burst = (grant == last_reg) ? burst_reg + BW'(1) : BW'(1);

    state_next  = state_reg;
    ptr_next    = ptr_reg;
    last_next   = last_reg;
    burst_next  = burst_reg;
    o_data_next = o_data_reg;
    write_next  = 1'b0;
    ack_next    = flush;
    sel_next    = '0;

    case (state_reg)
      DECIDE: begin
        if (!fifo_full && found_lo) begin
          write_next  = 1'b1;
          ack_next    = flush | grant_onehot;
          sel_next    = grant_onehot;
          o_data_next = grant_data;
          last_next   = grant;
          state_next  = XFER;
          if (new_burst >= BW'(BURST_MAX)) begin
            ptr_next   = (grant == PW'(N - 1)) ? '0 : grant + PW'(1);
            burst_next = '0;
          end else begin
            ptr_next   = grant;
            burst_next = new_burst;
          end
        end
      end
      XFER: state_next = DECIDE;
      default: state_next = DECIDE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= DECIDE;
      ptr_reg    <= '0;
      last_reg   <= '0;
      burst_reg  <= '0;
      o_data_reg <= '0;
      write_reg  <= 1'b0;
      ack_reg    <= '0;
      sel_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      last_reg   <= last_next;
      burst_reg  <= burst_next;
      o_data_reg <= o_data_next;
      write_reg  <= write_next;
      ack_reg    <= ack_next;
      sel_reg    <= sel_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_drop
      logic [DW-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (reset || clear_drops) begin
          cnt_reg <= '0;
        end else if (flush[gi] && (cnt_reg != {DW{1'b1}})) begin
          cnt_reg <= cnt_reg + DW'(1);
        end
      end
      assign drop_count[gi*DW +: DW] = cnt_reg;
    end
  endgenerate

  assign o_data     = o_data_reg;
  assign write      = write_reg;
  assign req_ack    = ack_reg;
  assign sel_onehot = sel_reg;

endmodule
